// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
package display_pkg;

    // Width of the PWM brightness level (0 = 1/16 duty ... 15 = 16/16 duty).
    localparam int unsigned BRIGHT_W = 4;

    // All segments and the decimal point dark (outputs are active-low).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low hex glyphs, bit order g,f,e,d,c,b,a. Lowercase b and d.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, // 0
        7'h79, // 1
        7'h24, // 2
        7'h30, // 3
        7'h19, // 4
        7'h12, // 5
        7'h02, // 6
        7'h78, // 7
        7'h00, // 8
        7'h10, // 9
        7'h08, // A
        7'h03, // b
        7'h46, // C
        7'h21, // d
        7'h06, // E
        7'h0E  // F
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble + decimal point to active-low segment code.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_in,
    input  logic       dp_in,
    output logic [7:0] seg_out
);

    // Look up the glyph; the dp bit is pulled low when the point is lit.
    always_comb begin
        seg_out = {~dp_in, GLYPH[nibble_in]};
    end

endmodule

// File: rtl/display_7_seg_scan.sv
// Multiplexed seven-segment driver: double-buffered frame, digit scan with a
// refresh prescaler, per-slot PWM brightness and optional leading-zero blanking.
module display_7_seg_scan
    import display_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_in,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en_in,
    input  logic                  lz_blank_in,
    input  logic [BRIGHT_W-1:0]   brightness_in,
    output logic [7:0]            segment_out,
    output logic [DIGITS-1:0]     enable_out,
    output logic                  frame_out
);

    localparam int unsigned TW  = $clog2(PRESCALE);
    localparam int unsigned TW1 = TW + 1;
    localparam int unsigned DW  = $clog2(DIGITS);

    localparam logic [TW-1:0] TICK_LAST  = TW'(PRESCALE - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
    // On-time grows by PRESCALE/16 cycles per brightness step.
    localparam logic [TW:0]   ON_STEP    = TW1'(PRESCALE / 16);

    // Scan counters.
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] digit_q, digit_d;

    // Brightness latched at the start of every slot.
    logic [BRIGHT_W-1:0] bright_q, bright_d;

    // Active (displayed) buffer.
    logic [4*DIGITS-1:0] act_val_q, act_val_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   act_en_q, act_en_d;
    logic                act_lz_q, act_lz_d;

    // Pending buffer, promoted to active at the next frame boundary.
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                pend_lz_q, pend_lz_d;
    logic                pend_valid_q, pend_valid_d;

    // Registered outputs.
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] en_q, en_d;
    logic              frame_q;

    logic               tick_wrap;
    logic               boundary;
    logic [BRIGHT_W-1:0] bright_eff;
    logic [TW:0]        on_time;
    logic               in_on_time;
    logic [DIGITS-1:0]  blank_vec;
    logic               zero_run;
    logic               digit_lit;
    logic [3:0]         cur_nibble;
    logic               cur_dp;
    logic [7:0]         glyph_code;

    assign tick_wrap = (tick_q == TICK_LAST);
    assign boundary  = tick_wrap && (digit_q == DIGIT_LAST);

    // Tick wraps every slot; digit advances on each tick wrap.
    always_comb begin
        tick_d  = tick_q + TW'(1);
        digit_d = digit_q;
        if (tick_wrap) begin
            tick_d  = '0;
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
        end
    end

    // The slot's first cycle already uses the freshly sampled level so the
    // whole slot sees one consistent on-time.
    always_comb begin
        bright_eff = (tick_q == '0) ? brightness_in : bright_q;
        bright_d   = bright_eff;
        on_time    = (TW1'(bright_eff) + TW1'(1)) * ON_STEP;
        in_on_time = ({1'b0, tick_q} < on_time);
    end

    // Double buffer: a load on the boundary bypasses pending and drops any
    // older pending frame; otherwise pending is promoted at the boundary.
    always_comb begin
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        act_lz_d     = act_lz_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_lz_d    = pend_lz_q;
        pend_valid_d = pend_valid_q;
        if (boundary) begin
            if (load_in) begin
                act_val_d = value_in;
                act_dp_d  = dp_in;
                act_en_d  = digit_en_in;
                act_lz_d  = lz_blank_in;
            end else if (pend_valid_q) begin
                act_val_d = pend_val_q;
                act_dp_d  = pend_dp_q;
                act_en_d  = pend_en_q;
                act_lz_d  = pend_lz_q;
            end
            pend_valid_d = 1'b0;
        end else if (load_in) begin
            pend_val_d   = value_in;
            pend_dp_d    = dp_in;
            pend_en_d    = digit_en_in;
            pend_lz_d    = lz_blank_in;
            pend_valid_d = 1'b1;
        end
    end

    // Leading-zero run from the top digit down; digit 0 is never blanked.
    always_comb begin
        blank_vec = '0;
        zero_run  = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zero_run     = zero_run && (act_val_q[4*d +: 4] == 4'h0) && !act_dp_q[d];
            blank_vec[d] = act_lz_q && zero_run;
        end
    end

    // Select the scanned digit's nibble and decimal point.
    always_comb begin
        cur_nibble = act_val_q[{digit_q, 2'b00} +: 4];
        cur_dp     = act_dp_q[digit_q];
        digit_lit  = act_en_q[digit_q] && !blank_vec[digit_q];
    end

    hex_to_seg u_hex_to_seg (
        .nibble_in (cur_nibble),
        .dp_in     (cur_dp),
        .seg_out   (glyph_code)
    );

    // Drive one anode low during the on-time of a lit digit.
    always_comb begin
        seg_d = SEG_OFF;
        en_d  = '1;
        if (digit_lit && in_on_time) begin
            seg_d         = glyph_code;
            en_d[digit_q] = 1'b0;
        end
    end

    // Counters and brightness latch.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tick_q   <= '0;
            digit_q  <= '0;
            bright_q <= '0;
        end else begin
            tick_q   <= tick_d;
            digit_q  <= digit_d;
            bright_q <= bright_d;
        end
    end

    // Active and pending frame buffers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            act_lz_q     <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_lz_q    <= 1'b0;
            pend_valid_q <= 1'b0;
        end else begin
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            act_lz_q     <= act_lz_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_lz_q    <= pend_lz_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // Output registers: one cycle behind the counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            seg_q   <= SEG_OFF;
            en_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            en_q    <= en_d;
            frame_q <= boundary;
        end
    end

    assign segment_out = seg_q;
    assign enable_out  = en_q;
    assign frame_out   = frame_q;

endmodule

// File: tb/tb_display_7_seg_scan.sv
// Self-checking bench for display_7_seg_scan (DIGITS=4, PRESCALE=16).
module tb_display_7_seg_scan;

    localparam int D = 4;
    localparam int P = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_in = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en_in = '0;
    logic        lz_blank_in = 1'b0;
    logic [3:0]  brightness_in = '0;
    logic [7:0]  segment_out;
    logic [3:0]  enable_out;
    logic        frame_out;

    int compared = 0;
    int mismatched = 0;

    // Reference model state: cycle position within the scan plus both buffers.
    int          n;
    logic [15:0] a_val, p_val;
    logic [3:0]  a_dp, a_en, p_dp, p_en;
    logic        a_lz, p_lz, pv;
    logic [3:0]  bl;
    logic [7:0]  glyph8 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int          low_cnt [4];
    int          frame_cnt;

    display_7_seg_scan #(.DIGITS(D), .PRESCALE(P)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .load_in       (load_in),
        .value_in      (value_in),
        .dp_in         (dp_in),
        .digit_en_in   (digit_en_in),
        .lz_blank_in   (lz_blank_in),
        .brightness_in (brightness_in),
        .segment_out   (segment_out),
        .enable_out    (enable_out),
        .frame_out     (frame_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at n=%0d: observed %h, expected %h", tag, n, obs, exp);
        end
    endtask

    function automatic logic digit_dark(input int d);
        if (!a_en[d]) return 1'b1;
        if (a_lz && d != 0) begin
            for (int k = d; k < D; k++)
                if (a_val[4*k +: 4] != 4'h0 || a_dp[k]) return 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_counts();
        for (int d = 0; d < D; d++) low_cnt[d] = 0;
        frame_cnt = 0;
    endtask

    // One clock: predict outputs from the pre-edge model, advance model, compare.
    task automatic step();
        logic [7:0] es;
        logic [3:0] ee;
        logic       ef;
        int         tick, dig, on;
        logic [3:0] be;
        logic       bnd;
        es = 8'hFF; ee = 4'hF; ef = 1'b0;
        if (!reset_n) begin
            n = 0; a_val = '0; a_dp = '0; a_en = '0; a_lz = 0;
            p_val = '0; p_dp = '0; p_en = '0; p_lz = 0; pv = 0; bl = '0;
        end else begin
            tick = n % P;
            dig  = n / P;
            bnd  = (tick == P - 1) && (dig == D - 1);
            be   = (tick == 0) ? brightness_in : bl;
            on   = (int'(be) + 1) * P / 16;
            if (!digit_dark(dig) && tick < on) begin
                ee = ~(4'b0001 << dig);
                es = glyph8[a_val[4*dig +: 4]];
                if (a_dp[dig]) es[7] = 1'b0;
            end
            ef = bnd;
            if (tick == 0) bl = brightness_in;
            if (bnd) begin
                if (load_in) begin
                    a_val = value_in; a_dp = dp_in; a_en = digit_en_in; a_lz = lz_blank_in;
                end else if (pv) begin
                    a_val = p_val; a_dp = p_dp; a_en = p_en; a_lz = p_lz;
                end
                pv = 1'b0;
            end else if (load_in) begin
                p_val = value_in; p_dp = dp_in; p_en = digit_en_in; p_lz = lz_blank_in;
                pv = 1'b1;
            end
            n = (n + 1) % (D * P);
        end
        @(posedge clock);
        #1;
        check("segment_out", 32'(segment_out), 32'(es));
        check("enable_out", 32'(enable_out), 32'(ee));
        check("frame_out", 32'(frame_out), 32'(ef));
        for (int d = 0; d < D; d++) if (enable_out[d] == 1'b0) low_cnt[d]++;
        if (frame_out) frame_cnt++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                           input logic lz);
        value_in = v; dp_in = dp; digit_en_in = en; lz_blank_in = lz;
        load_in = 1'b1;
        step();
        load_in = 1'b0;
    endtask

    initial begin
        n = 0;
        clear_counts();
        // Reset held for three cycles.
        reset_n = 1'b0;
        run(3);
        reset_n = 1'b1;

        // 1234 at full brightness.
        brightness_in = 4'd15;
        do_load(16'h1234, 4'h0, 4'hF, 1'b0);
        run(64);
        clear_counts();
        run(64);
        for (int d = 0; d < D; d++) check("on_cycles_b15", 32'(low_cnt[d]), 32'd16);
        check("frame_pulses", 32'(frame_cnt), 32'd1);

        // Brightness 3: four lit cycles per slot.
        brightness_in = 4'd3;
        run(64);
        clear_counts();
        run(64);
        for (int d = 0; d < D; d++) check("on_cycles_b3", 32'(low_cnt[d]), 32'd4);

        // Leading-zero blanking of 0070.
        brightness_in = 4'd15;
        do_load(16'h0070, 4'h0, 4'hF, 1'b1);
        run(64);
        clear_counts();
        run(64);
        check("lz_d3_dark", 32'(low_cnt[3]), 32'd0);
        check("lz_d2_dark", 32'(low_cnt[2]), 32'd0);
        check("lz_d1_lit", 32'(low_cnt[1]), 32'd16);
        check("lz_d0_lit", 32'(low_cnt[0]), 32'd16);

        // Lit dp on digit 2 stops blanking there.
        do_load(16'h0005, 4'b0100, 4'hF, 1'b1);
        run(64);
        clear_counts();
        run(64);
        check("dp_d3_dark", 32'(low_cnt[3]), 32'd0);
        check("dp_d2_lit", 32'(low_cnt[2]), 32'd16);

        // Mid-frame load, then a load exactly on the boundary cycle.
        while (n != 20) step();
        do_load(16'hABCD, 4'h1, 4'hF, 1'b0);
        while (n != D * P - 1) step();
        do_load(16'h9876, 4'h0, 4'hF, 1'b0);
        run(128);

        // Randomised traffic, including one mid-operation reset.
        for (int i = 0; i < 900; i++) begin
            if (i == 450) begin
                reset_n = 1'b0;
                run(2);
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) brightness_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0 || (n == D * P - 1 && $urandom_range(0, 1) == 1))
                do_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            else
                step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/display_7_seg_scan.md
# display_7_seg_scan

Parametrised multiplexed seven-segment display driver: the next generation of `display_7_seg`, extended from a fixed digit count to `DIGITS` digits. It holds a double-buffered frame of hex values, scans the digits with a programmable refresh prescaler, and applies per-digit PWM brightness and optional leading-zero blanking. It sits between the board's segment/anode pins and any logic that publishes numeric values.

## Interface
- `DIGITS`, 4, number of scanned digits (2..8)
- `PRESCALE`, 1024, clock cycles per digit slot; multiple of 16, ≥16
- `clock` in 1: single clock for all logic
- `reset_n` in 1: synchronous reset, active-low (one clock; reset is synchronous and active-low)
- `load_in` in 1: one-cycle strobe that captures `value_in`, `dp_in`, `digit_en_in` and `lz_blank_in` into the pending buffer
- `value_in` in 4*DIGITS: nibble d is the value for digit d; digit 0 is least significant/rightmost
- `dp_in` in DIGITS: decimal point per digit, 1 = lit
- `digit_en_in` in DIGITS: per-digit enable, 0 = digit dark
- `lz_blank_in` in 1: enables leading-zero blanking
- `brightness_in` in 4: duty level, 0 = 1/16 … 15 = 16/16
- `segment_out` out 8: active-low; bit7 = dp, bits 6:0 = g,f,e,d,c,b,a
- `enable_out` out DIGITS: active-low digit anodes; at most one bit low
- `frame_out` out 1: one-cycle pulse on the last cycle of each full scan

## Operation
- Counters: `tick` (0..PRESCALE-1) and `digit` (0..DIGITS-1). `tick` wraps every slot. `digit` increments when `tick` wraps and wraps from DIGITS-1 to 0.
- Frame boundary: the cycle with `tick`=PRESCALE-1 and `digit`=DIGITS-1. `frame_out` is high for that cycle only.
- Double buffer:
  - `load_in` writes the pending registers and sets `pend_valid`.
  - At a frame boundary, if `pend_valid`, pending is copied to active and `pend_valid` clears.
  - If `load_in` coincides with a boundary, the new inputs go directly to active and `pend_valid` stays clear.
  - Repeated loads within a frame: the last one wins.
- Brightness: latched at `tick`=0 of each slot. On-time is `on = (b+1)*PRESCALE/16` cycles. A digit's anode is driven while `tick < on`.
- Digit dark when any of the following holds:
  - `digit_en`[d] = 0;
  - leading-zero blanked: `lz_blank` set, d ≠ 0, and every active nibble from DIGITS-1 down to d is 0 with its dp bit clear.
- A dark digit keeps `enable_out` all ones and `segment_out` = 8'hFF for its whole slot.
- Glyphs are standard hex, with lowercase b and d. Active-low codes: 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90, A = 88, b = 83, C = C6, d = A1, E = 86, F = 8E. The dp bit is cleared when lit.
- Outside the on-time, `segment_out` = 8'hFF.

## Timing
- Reset values:
  - `segment_out` = 8'hFF, `enable_out` = all ones, `frame_out` = 0;
  - `tick`, `digit`, active and pending buffers = 0, `pend_valid` = 0;
  - latched brightness = 0.
- Mid-operation reset aborts the scan and any pending load in the same cycle.
- All outputs are registered and lag the counters by one cycle, `frame_out` included. The first anode assertion is visible after the 2nd rising edge with `reset_n` high.
- Scan period is DIGITS*PRESCALE cycles.
- Load latency: a value appears from the slot-0 start after the next boundary, at most DIGITS*PRESCALE+1 cycles after `load_in`.
- `brightness_in` changes mid-slot take effect at the next slot.
- Switching `enable_out` between digits always passes through one all-ones cycle, except when `brightness_in` = 15.

## Structure
- Package `display_pkg` holds:
  - the 16-entry glyph constant array (7-bit, active-low);
  - `SEG_OFF` = 8'hFF;
  - the brightness width.
- Sub-module `hex_to_seg`: combinational nibble + dp → 8-bit active-low code, reading the package array.
- Everything else lives in `display_7_seg_scan`: counters, buffers, blanking and PWM compare.

## Test plan
All scenarios use DIGITS=4, PRESCALE=16.
- Reset: hold `reset_n`=0 for 3 cycles → `segment_out`=FF, `enable_out`=4'hF, `frame_out`=0 throughout.
- Load 16'h1234, dp=0, enables=F, b=15 → next frame shows digit0 = 99 and digit3 = F9. Each anode is low for exactly 16 cycles; `frame_out` pulses every 64 cycles.
- Brightness 3 → each anode is low for 4 cycles per 16-cycle slot and `segment_out`=FF for the other 12.
- Load 16'h0070 with `lz_blank_in`=1 → digits 3 and 2 stay dark; digit1 = F8; digit0 = C0, never blanked.
- Load 16'h0005 with dp[2]=1 and `lz_blank_in`=1 → digit3 dark; digit2 = 40 (0 with dp lit). Blanking stops there.
- Issue `load_in` mid-frame and again on the boundary cycle → the current frame is unchanged and the boundary-cycle value is displayed from the next frame.
